// File: rtl/sid_dac_rx.sv
// Receiver for the SID two-channel serial DAC stream: oversamples DAC_clk/DAC_le/data,
// deserializes one 16-bit frame per channel per DAC_le window and buffers it for a consumer.
module sid_dac_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SAMPLE_W    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dac_clk,
  input  logic                           dac_le,
  input  logic                           dac_dat_1,
  input  logic                           dac_dat_2,
  output logic [SAMPLE_W-1:0]            sample_1,
  output logic [SAMPLE_W-1:0]            sample_2,
  output logic [FRAME_BITS-SAMPLE_W-1:0] cfg_1,
  output logic [FRAME_BITS-SAMPLE_W-1:0] cfg_2,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic                           frame_err,
  output logic                           overrun,
  input  logic                           err_clr
);

  localparam int CFG_W = FRAME_BITS - SAMPLE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLOSE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, le_sync_q, d1_sync_q, d2_sync_q;
  logic                   clk_prev_q, le_prev_q;
  logic                   clk_s, le_s, d1_s, d2_s;
  logic                   clk_rise_s, le_rise_s, le_fall_s;

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  sh1_q, sh1_d, sh2_q, sh2_d;
  logic                   load_s, ferr_set_s, ovr_set_s, hs_s;

  logic [SAMPLE_W-1:0]    s1_q, s1_d, s2_q, s2_d;
  logic [CFG_W-1:0]       c1_q, c1_d, c2_q, c2_d;
  logic                   valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

  // Input synchronizers plus one extra stage per control line for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= '0;
      le_sync_q  <= '0;
      d1_sync_q  <= '0;
      d2_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      le_prev_q  <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], dac_clk};
      le_sync_q  <= {le_sync_q[SYNC_STAGES-2:0], dac_le};
      d1_sync_q  <= {d1_sync_q[SYNC_STAGES-2:0], dac_dat_1};
      d2_sync_q  <= {d2_sync_q[SYNC_STAGES-2:0], dac_dat_2};
      clk_prev_q <= clk_s;
      le_prev_q  <= le_s;
    end
  end

  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign le_s       = le_sync_q[SYNC_STAGES-1];
  assign d1_s       = d1_sync_q[SYNC_STAGES-1];
  assign d2_s       = d2_sync_q[SYNC_STAGES-1];
  assign clk_rise_s = clk_s & ~clk_prev_q;
  assign le_rise_s  = le_s & ~le_prev_q;
  assign le_fall_s  = ~le_s & le_prev_q;

  // Frame FSM: a bit arriving with the closing latch edge is still shifted in
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    load_s     = 1'b0;
    ferr_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (le_fall_s) begin
          state_d = SHIFT;
          cnt_d   = 5'd0;
          sh1_d   = '0;
          sh2_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (clk_rise_s) begin
          sh1_d = {sh1_q[FRAME_BITS-2:0], d1_s};
          sh2_d = {sh2_q[FRAME_BITS-2:0], d2_s};
          cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (le_rise_s) begin
          state_d = CLOSE;
        end else begin
          state_d = SHIFT;
        end
      end
      CLOSE: begin
        state_d = IDLE;
        if (cnt_q == 5'(FRAME_BITS)) begin
          load_s = 1'b1;
        end else begin
          ferr_set_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single-entry output buffer; a load on the handshake cycle is not an overrun
  always_comb begin
    hs_s      = valid_q & sample_ready;
    s1_d      = s1_q;
    s2_d      = s2_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    ovr_set_s = 1'b0;
    if (load_s) begin
      s1_d      = sh1_q[SAMPLE_W-1:0];
      c1_d      = sh1_q[FRAME_BITS-1:SAMPLE_W];
      s2_d      = sh2_q[SAMPLE_W-1:0];
      c2_d      = sh2_q[FRAME_BITS-1:SAMPLE_W];
      valid_d   = 1'b1;
      ovr_set_s = valid_q & ~sample_ready;
    end else begin
      valid_d = valid_q & ~hs_s;
    end
    ferr_d = ferr_set_s | (ferr_q & ~err_clr);
    ovr_d  = ovr_set_s | (ovr_q & ~err_clr);
  end

  // State, shift and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_1     = s1_q;
  assign sample_2     = s2_q;
  assign cfg_1        = c1_q;
  assign cfg_2        = c2_q;
  assign sample_valid = valid_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_sid_dac_rx.sv
// Bench for sid_dac_rx: drives serial DAC frames, predicts accepted frames into a queue,
// and a monitor compares every handshaken output against that queue.
module tb_sid_dac_rx;

  logic        clk = 1'b0, rst = 1'b0;
  logic        dac_clk = 1'b0, dac_le = 1'b1, dat1 = 1'b0, dat2 = 1'b0;
  logic        ready = 1'b0, err_clr = 1'b0;
  logic [11:0] s1, s2;
  logic [3:0]  c1, c2;
  logic        valid, ferr, ovr;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_acc = 32'h0;
  logic [31:0] rd1, rd2;

  sid_dac_rx dut (
    .clk(clk), .rst(rst), .dac_clk(dac_clk), .dac_le(dac_le),
    .dac_dat_1(dat1), .dac_dat_2(dat2),
    .sample_1(s1), .sample_2(s2), .cfg_1(c1), .cfg_2(c2),
    .sample_valid(valid), .sample_ready(ready),
    .frame_err(ferr), .overrun(ovr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a 16-bit frame is accepted whole; cfg is its top nibble, sample the rest.
  // A frame landing on a still-unconsumed one (consumer stalled) replaces it.
  task automatic expect_frame(input int n, input logic [31:0] d1, input logic [31:0] d2,
                              input bit overwrite);
    logic [31:0] w;
    if (n == 16) begin
      w = {d1[15:0], d2[15:0]};
      last_acc = w;
      if (overwrite && exp_q.size() > 0) exp_q[exp_q.size()-1] = w;
      else exp_q.push_back(w);
    end
  endtask

  // Monitor: every accepted handshake must match the oldest predicted frame
  always @(negedge clk) begin
    if (rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got %h expected none", {c1, s1, c2, s2});
      end else begin
        chk("frame_data", 40'({c1, s1, c2, s2}), 40'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int n, input logic [31:0] d1, input logic [31:0] d2,
                           input int lo, input int hi, input bit align);
    for (int i = n - 1; i >= 0; i--) begin
      dac_clk = 1'b0;
      dat1 = d1[i];
      dat2 = d2[i];
      cyc(lo);
      dac_clk = 1'b1;
      if (i == 0 && align) dac_le = 1'b1;
      cyc(hi);
    end
  endtask

  task automatic frame_start();
    dac_le = 1'b0;
    cyc(4);
  endtask

  task automatic frame_end();
    dac_clk = 1'b0;
    dac_le = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("reset_outputs", 40'({ovr, ferr, valid, c1, s1, c2, s2}), 40'h0);
    rst = 1'b1;
    cyc(6);

    // Nominal frame with latency check
    ready = 1'b1;
    frame_start();
    send_bits(16, 32'h3ABC, 32'h7123, 4, 4, 1'b0);
    expect_frame(16, 32'h3ABC, 32'h7123, 1'b0);
    frame_end();
    repeat (4) @(negedge clk);
    chk("latency_early", 40'(valid), 40'h0);
    @(negedge clk);
    chk("latency_valid", 40'(valid), 40'h1);
    chk("nominal_word", 40'({c1, s1, c2, s2}), 40'h3ABC7123);
    chk("nominal_flags", 40'({ferr, ovr}), 40'h0);
    cyc(4);

    // Randomized frames and bit-clock phases
    for (int k = 0; k < 6; k++) begin
      int lo, hi;
      rd1 = 32'($urandom_range(16'hFFFF, 0));
      rd2 = 32'($urandom_range(16'hFFFF, 0));
      lo = int'($urandom_range(6, 3));
      hi = int'($urandom_range(6, 3));
      frame_start();
      send_bits(16, rd1, rd2, lo, hi, 1'b0);
      expect_frame(16, rd1, rd2, 1'b0);
      frame_end();
      cyc(10);
      chk("rand_flags", 40'({ferr, ovr, valid}), 40'h0);
    end

    // Short frame, error clear, long frame
    rd1 = 32'($urandom_range(16'hFFFF, 0));
    frame_start();
    send_bits(15, rd1, ~rd1, 4, 4, 1'b0);
    expect_frame(15, rd1, ~rd1, 1'b0);
    frame_end();
    cyc(10);
    chk("short_novalid", 40'(valid), 40'h0);
    chk("short_err", 40'(ferr), 40'h1);
    pulse_clr();
    chk("err_clr", 40'(ferr), 40'h0);
    frame_start();
    send_bits(17, 32'h1A5A5, 32'h05A5A, 4, 4, 1'b0);
    expect_frame(17, 32'h1A5A5, 32'h05A5A, 1'b0);
    frame_end();
    cyc(10);
    chk("long_err", 40'(ferr), 40'h1);
    chk("long_unchanged", 40'({c1, s1, c2, s2}), 40'(last_acc));
    pulse_clr();

    // Backpressure: second frame overwrites unconsumed first
    ready = 1'b0;
    frame_start();
    send_bits(16, 32'h0111, 32'h0AAA, 4, 4, 1'b0);
    expect_frame(16, 32'h0111, 32'h0AAA, 1'b0);
    frame_end();
    cyc(10);
    chk("bp_first_no_ovr", 40'(ovr), 40'h0);
    frame_start();
    send_bits(16, 32'h0222, 32'h0BBB, 4, 4, 1'b0);
    expect_frame(16, 32'h0222, 32'h0BBB, 1'b1);
    frame_end();
    cyc(10);
    chk("bp_sample", 40'(s1), 40'h222);
    chk("bp_overrun", 40'(ovr), 40'h1);
    chk("bp_valid", 40'(valid), 40'h1);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("bp_drained", 40'(valid), 40'h0);
    pulse_clr();
    chk("ovr_clr", 40'(ovr), 40'h0);

    // Handshake in the exact load cycle of the next frame
    frame_start();
    send_bits(16, 32'h9C3D, 32'h4E21, 4, 4, 1'b0);
    expect_frame(16, 32'h9C3D, 32'h4E21, 1'b0);
    frame_end();
    cyc(10);
    frame_start();
    send_bits(16, 32'hF0E1, 32'h2D3C, 4, 4, 1'b0);
    expect_frame(16, 32'hF0E1, 32'h2D3C, 1'b0);
    frame_end();
    cyc(3);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("coll_valid", 40'(valid), 40'h1);
    chk("coll_no_ovr", 40'(ovr), 40'h0);
    chk("coll_word", 40'({c1, s1, c2, s2}), 40'hF0E12D3C);
    ready = 1'b1;
    cyc(3);

    // Reset mid-frame
    frame_start();
    send_bits(8, 32'hFFFF, 32'hFFFF, 4, 4, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_reset", 40'({ovr, ferr, valid, c1, s1, c2, s2}), 40'h0);
    cyc(2);
    rst = 1'b1;
    send_bits(8, 32'hFF, 32'hFF, 4, 4, 1'b0);
    frame_end();
    cyc(10);
    chk("rst_no_valid", 40'(valid), 40'h0);
    chk("rst_no_err", 40'(ferr), 40'h0);
    rd1 = 32'($urandom_range(16'hFFFF, 0));
    rd2 = 32'($urandom_range(16'hFFFF, 0));
    frame_start();
    send_bits(16, rd1, rd2, 4, 4, 1'b0);
    expect_frame(16, rd1, rd2, 1'b0);
    frame_end();
    cyc(10);

    // Last bit clock rise coincident with the latch rise
    frame_start();
    send_bits(16, 32'h8421, 32'h1248, 4, 4, 1'b1);
    expect_frame(16, 32'h8421, 32'h1248, 1'b0);
    cyc(8);
    dac_clk = 1'b0;
    cyc(4);
    chk("align_no_err", 40'(ferr), 40'h0);

    cyc(5);
    chk("queue_empty", 40'(exp_q.size()), 40'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
